// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: operation codes, FSM state constants,
// default datapath width and the sign-correction record carried to FIX.
package hilo_pkg;

    localparam int HILO_W = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_MTHI = 2'd2,
        OP_MTLO = 2'd3
    } op_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FIX    = 2'd3;

    // Quotient is negated when operand signs differ; remainder follows the dividend.
    typedef struct packed {
        logic q_neg;
        logic r_neg;
    } fix_t;

endpackage

// File: rtl/hilo_unit_sign_fix.sv
// sign_fix: two-lane conditional two's-complement negate. Used as |x| on entry
// to the divider and as sign restoration on the divider's unsigned results.
module sign_fix
    import hilo_pkg::*;
#(
    parameter int W = HILO_W
) (
    input  logic [W-1:0] a_i,
    input  logic         a_neg_i,
    input  logic [W-1:0] b_i,
    input  logic         b_neg_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    // Negating the most negative value wraps back onto itself, which is what
    // the divider expects as the magnitude 2^(W-1).
    assign a_o = a_neg_i ? (~a_i + W'(1)) : a_i;
    assign b_o = b_neg_i ? (~b_i + W'(1)) : b_i;

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers with DIV/DIVU via an external sequential
// unsigned divider. Define HILO_DIV0_TRAP_EN to get a div0_trap pulse on divide-by-zero.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int W       = HILO_W,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         op_valid,
    input  logic [1:0]   op_code,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    output logic         busy,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dv_start,
    output logic [W-1:0] dv_a,
    output logic [W-1:0] dv_b,
    input  logic         dv_done,
    input  logic [W-1:0] dv_q,
    input  logic [W-1:0] dv_r,
    output logic         timeout_err,
    output logic         div0_trap
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [W-1:0]     dv_a_q, dv_a_d;
    logic [W-1:0]     dv_b_q, dv_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fix_t             fix_q, fix_d;
    logic             tmo_q, tmo_d;
    logic             done_q;
    logic [W-1:0]     q_raw_q, r_raw_q;

    logic             op_signed;
    logic             is_div_op;
    logic             div0_req;
    logic [W-1:0]     rs_mag, rt_mag;
    logic [W-1:0]     q_fix, r_fix;

    assign op_signed = (op_code == OP_DIV);
    assign is_div_op = (op_code == OP_DIV) || (op_code == OP_DIVU);
    assign div0_req  = (state_q == ST_IDLE) && op_valid && is_div_op && (rt_val == '0);

    sign_fix #(.W(W)) u_entry (
        .a_i     (rs_val),
        .a_neg_i (op_signed & rs_val[W-1]),
        .b_i     (rt_val),
        .b_neg_i (op_signed & rt_val[W-1]),
        .a_o     (rs_mag),
        .b_o     (rt_mag)
    );

    sign_fix #(.W(W)) u_fix (
        .a_i     (q_raw_q),
        .a_neg_i (fix_q.q_neg),
        .b_i     (r_raw_q),
        .b_neg_i (fix_q.r_neg),
        .a_o     (q_fix),
        .b_o     (r_fix)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dv_a_d  = dv_a_q;
        dv_b_d  = dv_b_q;
        cnt_d   = cnt_q;
        fix_d   = fix_q;
        tmo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_code)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: begin
                            if (rt_val != '0) begin
                                dv_a_d      = rs_mag;
                                dv_b_d      = rt_mag;
                                fix_d.q_neg = op_signed & (rs_val[W-1] ^ rt_val[W-1]);
                                fix_d.r_neg = op_signed & rs_val[W-1];
                                busy_d      = 1'b1;
                                state_d     = ST_LAUNCH;
                            end
                        end
                    endcase
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_q) begin
                    state_d = ST_FIX;
                end else if (cnt_q == CNT_LAST) begin
                    tmo_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                lo_d    = q_fix;
                hi_d    = r_fix;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dv_a_q  <= '0;
            dv_b_q  <= '0;
            cnt_q   <= '0;
            fix_q   <= '0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dv_a_q  <= dv_a_d;
            dv_b_q  <= dv_b_d;
            cnt_q   <= cnt_d;
            fix_q   <= fix_d;
            tmo_q   <= tmo_d;
            // Divider results are sampled one cycle late; pulses outside WAIT are dropped here.
            done_q  <= dv_done && (state_q == ST_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (dv_done && (state_q == ST_WAIT)) begin
            q_raw_q <= dv_q;
            r_raw_q <= dv_r;
        end
    end

`ifdef HILO_DIV0_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= div0_req;
        end
    end

    assign div0_trap = trap_q;
`else
    logic unused_div0;

    assign unused_div0 = div0_req;
    assign div0_trap   = 1'b0;
`endif

    assign busy        = busy_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dv_start    = (state_q == ST_LAUNCH);
    assign dv_a        = dv_a_q;
    assign dv_b        = dv_b_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: architectural model of HI/LO/busy plus literal checks.
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int W   = 32;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         op_valid;
    logic [1:0]   op_code;
    logic [W-1:0] rs_val, rt_val;
    logic         busy, dv_start, dv_done, timeout_err, div0_trap;
    logic [W-1:0] hi, lo, dv_a, dv_b, dv_q, dv_r;

    always #5 clk = ~clk;

    hilo_unit #(.W(W), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .dv_start    (dv_start),
        .dv_a        (dv_a),
        .dv_b        (dv_b),
        .dv_done     (dv_done),
        .dv_q        (dv_q),
        .dv_r        (dv_r),
        .timeout_err (timeout_err),
        .div0_trap   (div0_trap)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

`ifdef HILO_DIV0_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    // Architectural result of a division: {hi, lo}
    function automatic logic [63:0] div_result(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Model: an accepted division keeps the unit busy 3+D cycles (or TIMEOUT+1 if the divider never answers)
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_left = 0;
    bit          m_abort = 0, m_start = 0, m_tmo = 0, m_trap = 0;
    int          cur_d = 33;
    bit          withhold = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
            m_start = 0; m_tmo = 0; m_trap = 0;
        end else begin
            m_start = 0; m_tmo = 0; m_trap = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_abort) m_tmo = 1;
                    else begin m_hi = p_hi; m_lo = p_lo; end
                end
            end else if (op_valid) begin
                if (op_code == OP_MTHI) m_hi = rs_val;
                else if (op_code == OP_MTLO) m_lo = rs_val;
                else if (rt_val == 0) m_trap = TRAP_ON;
                else begin
                    {p_hi, p_lo} = div_result(op_code == OP_DIV, rs_val, rt_val);
                    m_abort = withhold;
                    m_left  = withhold ? TMO + 1 : cur_d + 3;
                    m_start = 1;
                end
            end
        end
    end

    // Divider model: answers D cycles after the start pulse; late_cnt requests a stray done pulse
    bit          auto_div = 1;
    int          late_cnt = 0;
    int          late_served = 0;
    logic [31:0] la, lb;

    initial begin
        dv_done = 0; dv_q = '0; dv_r = '0;
        forever begin
            @(negedge clk);
            if (late_cnt != late_served) begin
                late_served = late_cnt;
                dv_q = 32'd7; dv_r = 32'd1; dv_done = 1;
                @(negedge clk);
                dv_done = 0;
            end else if (dv_start && auto_div && reset) begin
                la = dv_a; lb = dv_b;
                repeat (cur_d) @(negedge clk);
                dv_q = la / lb; dv_r = la % lb; dv_done = 1;
                @(negedge clk);
                dv_done = 0;
            end
        end
    end

    bit chk_en = 0;
    int busy_cycles = 0, tmo_pulses = 0, start_pulses = 0;

    always @(negedge clk) begin
        if (reset && chk_en) begin
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("busy", busy, m_left > 0);
            check("dv_start", dv_start, m_start);
            check("timeout_err", timeout_err, m_tmo);
            check("div0_trap", div0_trap, m_trap);
            if (busy) busy_cycles++;
            if (timeout_err) tmo_pulses++;
            if (dv_start) start_pulses++;
        end
    end

    // All stimulus tasks start and end at posedge+2
    task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        op_valid = 1; op_code = op; rs_val = rs; rt_val = rt;
        @(posedge clk); #2;
        op_valid = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_idle_bound", busy, 0);
        @(posedge clk); #2;
    endtask

    logic [31:0] t_rs[4]  = '{32'h0000_0064, 32'hFFFF_FF9C, 32'h0000_0064, 32'h0000_0005};
    logic [31:0] t_rt[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0000_0007, 32'h0000_000A};
    logic [1:0]  t_op[4]  = '{2'd0, 2'd0, 2'd1, 2'd0};
    int          t_d[4]   = '{1, 2, 4, 10};
    logic [31:0] t_lo[4]  = '{32'hFFFF_FFF2, 32'h0000_000E, 32'h0000_000E, 32'h0000_0000};
    logic [31:0] t_hi[4]  = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0005};

    initial begin
        int b0, s0, t0;
        op_valid = 0; op_code = 0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk); #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_dv_start", dv_start, 0);
        check("rst_dv_a", dv_a, 0);
        check("rst_dv_b", dv_b, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_div0_trap", div0_trap, 0);
        reset = 1; chk_en = 1;
        @(posedge clk); #2;

        // DIV -7/2 with D=33, plus an MTHI during the division that must be ignored
        cur_d = 33; b0 = busy_cycles;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        repeat (4) @(posedge clk); #2;
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        wait_idle(200);
        check("div_busy_cycles", busy_cycles - b0, 36);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU passes raw operands
        cur_d = 5;
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'h2);
        @(negedge clk);
        check("divu_start", dv_start, 1);
        check("divu_dv_a", dv_a, 32'hFFFF_FFF9);
        check("divu_dv_b", dv_b, 32'h2);
        wait_idle(200);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h1);

        // Overflow wraps
        cur_d = 3;
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(200);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // Divide by zero: no launch, no stall
        s0 = start_pulses;
        issue(OP_DIV, 32'h1234, 32'h0);
        @(negedge clk);
        check("div0_busy", busy, 0);
        check("div0_trap_pulse", div0_trap, TRAP_ON);
        repeat (3) @(negedge clk);
        check("div0_no_start", start_pulses - s0, 0);
        check("div0_lo_kept", lo, 32'h8000_0000);
        check("div0_hi_kept", hi, 32'h0);
        @(posedge clk); #2;

        // MTHI then MTLO back to back
        op_valid = 1; op_code = OP_MTHI; rs_val = 32'h1234_5678;
        @(posedge clk); #2;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_lo_kept", lo, 32'h8000_0000);
        check("mthi_busy", busy, 0);
        op_code = OP_MTLO; rs_val = 32'hCAFE_BABE;
        @(posedge clk); #2;
        op_valid = 0;
        check("mtlo_lo", lo, 32'hCAFE_BABE);
        check("mtlo_busy", busy, 0);

        // Sign combinations
        for (int i = 0; i < 4; i++) begin
            cur_d = t_d[i];
            issue(t_op[i], t_rs[i], t_rt[i]);
            wait_idle(200);
            check($sformatf("tbl%0d_lo", i), lo, t_lo[i]);
            check($sformatf("tbl%0d_hi", i), hi, t_hi[i]);
        end

        // Reset during WAIT, then a stray done afterwards
        auto_div = 0;
        issue(OP_DIV, 32'd50, 32'd7);
        repeat (5) @(posedge clk); #2;
        reset = 0;
        @(negedge clk);
        check("rstw_hi", hi, 0);
        check("rstw_lo", lo, 0);
        check("rstw_busy", busy, 0);
        check("rstw_dv_a", dv_a, 0);
        check("rstw_dv_b", dv_b, 0);
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #2;
        late_cnt++;
        repeat (4) @(posedge clk); #2;
        check("late_hi", hi, 0);
        check("late_lo", lo, 0);
        check("late_busy", busy, 0);

        // Divider never answers
        withhold = 1;
        b0 = busy_cycles; t0 = tmo_pulses;
        issue(OP_DIV, 32'd9, 32'd3);
        wait_idle(200);
        repeat (2) @(posedge clk); #2;
        check("tmo_busy_cycles", busy_cycles - b0, TMO + 1);
        check("tmo_pulses", tmo_pulses - t0, 1);
        check("tmo_hi", hi, 0);
        check("tmo_lo", lo, 0);
        withhold = 0; auto_div = 1;

        // Recovery after abort
        cur_d = 2;
        issue(OP_DIVU, 32'd100, 32'd9);
        wait_idle(200);
        check("rec_lo", lo, 32'd11);
        check("rec_hi", hi, 32'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Architectural HI/LO register unit between the decode/execute stage and the sequential unsigned divider. Accepts DIV/DIVU/MTHI/MTLO operations, converts signed operands to magnitudes, launches the divider, waits for its result and applies sign correction. It then writes LO (quotient) and HI (remainder) and holds the pipeline stalled via `busy` for the whole division.

## Interface
Parameters:
- `W`, 32, operand/result width
- `TIMEOUT`, 64, max cycles in WAIT before abort (must exceed divider latency)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `op_valid`  in  1  operation request, sampled only when `busy`=0
- `op_code`  in  2  0=DIV, 1=DIVU, 2=MTHI, 3=MTLO
- `rs_val`  in  W  dividend / MTHI/MTLO source
- `rt_val`  in  W  divisor
- `busy`  out  1  division in progress; upstream must stall
- `hi`  out  W  HI register (remainder)
- `lo`  out  W  LO register (quotient)
- `dv_start`  out  1  one-cycle launch pulse to divider
- `dv_a`  out  W  dividend magnitude, stable from LAUNCH until dv_done
- `dv_b`  out  W  divisor magnitude, same stability
- `dv_done`  in  1  one-cycle pulse; `dv_q`/`dv_r` valid that cycle
- `dv_q`  in  W  unsigned quotient
- `dv_r`  in  W  unsigned remainder
- `timeout_err`  out  1  one-cycle pulse on WAIT abort
- `div0_trap`  out  1  one-cycle pulse on divide-by-zero (only with DIV0_TRAP_EN; otherwise tied 0)

## Operation
- States: IDLE, LAUNCH, WAIT, FIX.
- IDLE, op_valid, MTHI/MTLO: `hi`/`lo` <= `rs_val` at next edge; stay IDLE; `busy` stays 0.
- IDLE, op_valid, DIV/DIVU, `rt_val`≠0: latch operands and signedness; DIV takes |rs|, |rt| (two's-complement negate when bit W-1 set); DIVU passes raw values. Next state LAUNCH.
- IDLE, op_valid, DIV/DIVU, `rt_val`=0: no launch, HI/LO unchanged, stay IDLE (see Configuration).
- LAUNCH: `dv_start`=1 for exactly this cycle -> WAIT; cycle counter cleared.
- WAIT: capture `dv_q`/`dv_r` on `dv_done` -> FIX. Counter reaches TIMEOUT with no `dv_done`: pulse `timeout_err`, HI/LO unchanged -> IDLE.
- FIX: DIV: quotient negated if operand signs differ; remainder takes dividend sign. DIVU: no correction. Write `lo`=quotient, `hi`=remainder -> IDLE.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (wraps, no flag).
- op_valid while `busy`=1: ignored, no side effects.
- `dv_done` outside WAIT: ignored.
- Reset (any state, mid-division included): state IDLE, `hi`=`lo`=0, `busy`=0, `dv_start`=0, `dv_a`=`dv_b`=0, `timeout_err`=`div0_trap`=0, counter 0.

## Timing
- `busy` registered; 1 from the edge that accepts DIV/DIVU through the edge that writes HI/LO (FIX exit) or aborts.
- Latency from accept edge to HI/LO update: 3 + D cycles, where D = cycles from `dv_start` to `dv_done`.
- `hi`/`lo` are registered, always readable; new value visible the cycle after FIX.
- MTHI/MTLO: 1-cycle write latency, no stall.
- Divide-by-zero: 0 stall cycles; `div0_trap` (if enabled) asserted the cycle after accept.

## Configuration
- `HILO_DIV0_TRAP_EN` defined: divide-by-zero pulses `div0_trap` for one cycle; HI/LO unchanged.
- Undefined: `div0_trap` port present, constant 0; divide-by-zero silently leaves HI/LO unchanged.

## Structure
- Shared package `hilo_pkg`: `op_code` encodings (OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO), state enum, default W.
- One sub-module: `sign_fix`, combinational; provides magnitude (abs) on entry and conditional negate in FIX, parameterised by W. Instantiated twice (entry, fix) or shared.

## Test plan
- DIV rs=-7 (0xFFFFFFF9), rt=2, divider D=33 -> after 36 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); `busy` high exactly 36 cycles.
- DIVU rs=0xFFFFFFF9, rt=2 -> LO=0x7FFFFFFC, HI=1; `dv_a`=0xFFFFFFF9.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV rt=0 -> no `dv_start`, HI/LO unchanged; `div0_trap` pulses once only with HILO_DIV0_TRAP_EN.
- MTHI 0x12345678 then MTLO 0xCAFEBABE back-to-back -> hi/lo updated on consecutive edges, `busy` never 1; op_valid during a division ignored.
- Reset asserted during WAIT, then late `dv_done` -> hi=lo=0, IDLE, late done ignored; divider withheld > TIMEOUT -> `timeout_err` one pulse, `busy` falls.
